// File: rtl/ntt_gs_butterfly.sv
// ntt_gs_butterfly
//   Gentleman-Sande butterfly over the Goldilocks field p = 2^64 - 2^32 + 1:
//     out_x = (a + b) mod p
//     out_y = ((a - b) * w) mod p
//   Fully pipelined, one beat per cycle, valid-tagged, no backpressure.
//   The latency is fixed per MODE and built from the shared pipeline-depth
//   constants, so it matches the Cooley-Tukey butterfly schedule:
//     GENERIC : MODADDSUB + MUL64 + RED128T64 = 6 + 14 + 8 = 28
//     W0      : MODADDSUB                     = 6
//     W0_W2   : MODADDSUB + RED128T64         = 6 + 8      = 14
//
// Parameters
//   MODE   0 = BUTTERFLY_GENERIC (full multiply by in_w)
//          1 = BUTTERFLY_W0      (w = 1)
//          2 = BUTTERFLY_W0_W2   (w = 1 or 2^48, chosen by in_wsel)
//   TAG_W  sideband tag width
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid            input beat valid
//   in_a, in_b          canonical operands (< p)
//   in_w                canonical twiddle, GENERIC only
//   in_wsel             W0_W2 only: 0 -> w = 1, 1 -> w = 2^48
//   in_tag              sideband, returned unchanged with the beat
//   out_valid           in_valid delayed by exactly the latency
//   out_x, out_y        canonical results; hold while out_valid is low
//   out_tag             tag of the emerging beat
//
// Only the valid chain and the output register are reset; the data shift
// registers run free and are qualified by the valid chain.

// Plain N-stage delay line, no reset (N >= 1).
module ntt_gs_dly #(
    parameter int W = 64,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_sr [N];

    always_ff @(posedge clk) begin
        r_sr[0] <= i_d;
        for (int i = 1; i < N; i++) begin
            r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[N-1];
endmodule

module ntt_gs_butterfly #(
    parameter int MODE  = 0,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [63:0]      in_w,
    input  logic             in_wsel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [63:0]      out_x,
    output logic [63:0]      out_y,
    output logic [TAG_W-1:0] out_tag
);
    localparam int BUTTERFLY_GENERIC = 0;
    localparam int BUTTERFLY_W0      = 1;
    localparam int BUTTERFLY_W0_W2   = 2;

    localparam int PIPE_DEPTH_MODADDSUB = 6;
    localparam int PIPE_DEPTH_MUL64     = 14;
    localparam int PIPE_DEPTH_RED128T64 = 8;
    localparam int PIPE_DEPTH_MULRED    = PIPE_DEPTH_MUL64 + PIPE_DEPTH_RED128T64;

    localparam int LATENCY =
        (MODE == BUTTERFLY_GENERIC) ? PIPE_DEPTH_MODADDSUB + PIPE_DEPTH_MULRED :
        (MODE == BUTTERFLY_W0)      ? PIPE_DEPTH_MODADDSUB :
                                      PIPE_DEPTH_MODADDSUB + PIPE_DEPTH_RED128T64;

    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    // The stage plan below needs: 3 compute registers in add/sub, 2 in the
    // multiplier, 3 in the reducer plus the shared output register.
    if (MODE != BUTTERFLY_GENERIC && MODE != BUTTERFLY_W0 && MODE != BUTTERFLY_W0_W2) begin : g_bad_mode
        $error("ntt_gs_butterfly: unsupported MODE %0d", MODE);
    end
    if (PIPE_DEPTH_MODADDSUB < 3 || PIPE_DEPTH_MUL64 < 2 || PIPE_DEPTH_RED128T64 < 4) begin : g_bad_depth
        $error("ntt_gs_butterfly: pipeline depth constants too small for stage plan");
    end
    if (LATENCY < 6) begin : g_bad_lat
        $error("ntt_gs_butterfly: latency %0d inconsistent with depth constants", LATENCY);
    end

    // in_w / in_wsel are ignored in some modes.
    logic w_unused;
    assign w_unused = ^{in_w, in_wsel};

    // ---------------- stage 1: modular add / sub (stages 1..3 compute) ----
    logic [63:0] r_a, r_b;
    logic [64:0] r_sum, r_dif;
    logic [63:0] r_s, r_d;

    always_ff @(posedge clk) begin
        r_a   <= in_a;
        r_b   <= in_b;
        r_sum <= {1'b0, r_a} + {1'b0, r_b};
        r_dif <= {1'b0, r_a} - {1'b0, r_b};
        // sum < 2p, so one subtract is enough; s = p lands on 0
        r_s   <= (r_sum >= {1'b0, P}) ? 64'(r_sum - {1'b0, P}) : r_sum[63:0];
        // on borrow the low 64 bits hold a - b + 2^64; adding p wraps to a - b + p
        r_d   <= r_dif[64] ? r_dif[63:0] + P : r_dif[63:0];
    end

    // ---------------- delay-matched x and tag -----------------------------
    logic [63:0]      w_x_pre, w_y_pre;
    logic [TAG_W-1:0] w_tag_pre;

    ntt_gs_dly #(.W(64),    .N(LATENCY - 4)) u_x_dly   (.clk(clk), .i_d(r_s),    .o_q(w_x_pre));
    ntt_gs_dly #(.W(TAG_W), .N(LATENCY - 1)) u_tag_dly (.clk(clk), .i_d(in_tag), .o_q(w_tag_pre));

    // ---------------- stage 2 ---------------------------------------------
    if (MODE == BUTTERFLY_W0) begin : g_w0
        ntt_gs_dly #(.W(64), .N(LATENCY - 4)) u_y_dly (.clk(clk), .i_d(r_d), .o_q(w_y_pre));
    end else begin : g_red
        localparam logic [63:0] EPS = 64'h0000_0000_FFFF_FFFF;  // 2^64 mod p

        logic [63:0]  w_d_s1;
        logic [127:0] w_red_in;

        ntt_gs_dly #(.W(64), .N(PIPE_DEPTH_MODADDSUB - 3)) u_d_dly (.clk(clk), .i_d(r_d), .o_q(w_d_s1));

        if (MODE == BUTTERFLY_GENERIC) begin : g_mul
            logic [63:0]  w_w_s1;
            logic [63:0]  r_pp_ll, r_pp_lh, r_pp_hl, r_pp_hh;
            logic [127:0] r_prod;

            ntt_gs_dly #(.W(64), .N(PIPE_DEPTH_MODADDSUB)) u_w_dly (.clk(clk), .i_d(in_w), .o_q(w_w_s1));

            always_ff @(posedge clk) begin
                r_pp_ll <= {32'h0, w_d_s1[31:0]}  * {32'h0, w_w_s1[31:0]};
                r_pp_lh <= {32'h0, w_d_s1[31:0]}  * {32'h0, w_w_s1[63:32]};
                r_pp_hl <= {32'h0, w_d_s1[63:32]} * {32'h0, w_w_s1[31:0]};
                r_pp_hh <= {32'h0, w_d_s1[63:32]} * {32'h0, w_w_s1[63:32]};
                r_prod  <= {64'h0, r_pp_ll}
                         + ({64'h0, r_pp_lh} << 32)
                         + ({64'h0, r_pp_hl} << 32)
                         + {r_pp_hh, 64'h0};
            end

            ntt_gs_dly #(.W(128), .N(PIPE_DEPTH_MUL64 - 2)) u_prod_dly (.clk(clk), .i_d(r_prod), .o_q(w_red_in));
        end else begin : g_shift
            logic w_wsel_s1;

            ntt_gs_dly #(.W(1), .N(PIPE_DEPTH_MODADDSUB)) u_wsel_dly (.clk(clk), .i_d(in_wsel), .o_q(w_wsel_s1));

            // w = 2^48 is a pure shift; w = 1 passes d through the reducer
            // unchanged, which keeps both selections on the same latency.
            assign w_red_in = w_wsel_s1 ? {16'h0, w_d_s1, 48'h0} : {64'h0, w_d_s1};
        end

        // 128 -> 64 reduction: v = lo + hl*2^64 + hh*2^96
        //                        = lo + hl*(2^32 - 1) - hh  (mod p)
        logic [63:0] w_lo;
        logic [31:0] w_hl, w_hh;
        logic [64:0] w_t0_raw, w_sum;
        logic [63:0] r_t0, r_t1, r_r, r_y;

        assign w_lo     = w_red_in[63:0];
        assign w_hl     = w_red_in[95:64];
        assign w_hh     = w_red_in[127:96];
        assign w_t0_raw = {1'b0, w_lo} - {33'h0, w_hh};
        assign w_sum    = {1'b0, r_t0} + {1'b0, r_t1};

        always_ff @(posedge clk) begin
            // a wrap adds 2^64 == EPS, so take EPS back out; cannot underflow
            // because lo < hh < 2^32 leaves the wrapped value above EPS
            r_t0 <= w_t0_raw[64] ? w_t0_raw[63:0] - EPS : w_t0_raw[63:0];
            r_t1 <= {w_hl, 32'h0} - {32'h0, w_hl};
            // carry-out is worth EPS; the wrapped sum is small enough not to carry again
            r_r  <= w_sum[64] ? w_sum[63:0] + EPS : w_sum[63:0];
            r_y  <= (r_r >= P) ? r_r - P : r_r;
        end

        ntt_gs_dly #(.W(64), .N(PIPE_DEPTH_RED128T64 - 4)) u_y_dly (.clk(clk), .i_d(r_y), .o_q(w_y_pre));
    end

    // ---------------- valid chain and output register ---------------------
    logic [LATENCY-1:0] r_vld;
    logic [63:0]        r_out_x, r_out_y;
    logic [TAG_W-1:0]   r_out_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld     <= '0;
            r_out_x   <= '0;
            r_out_y   <= '0;
            r_out_tag <= '0;
        end else begin
            r_vld <= {r_vld[LATENCY-2:0], in_valid};
            if (r_vld[LATENCY-2]) begin
                r_out_x   <= w_x_pre;
                r_out_y   <= w_y_pre;
                r_out_tag <= w_tag_pre;
            end
        end
    end

    assign out_valid = r_vld[LATENCY-1];
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_tag   = r_out_tag;
endmodule

// File: tb/tb_ntt_gs_butterfly.sv
// Bench for ntt_gs_butterfly: one instance per MODE sharing a stimulus bus.
// Directed vectors come from a table; random traffic is checked every cycle
// against an arithmetic model (big-integer % p) with fixed per-mode latency.
module tb_ntt_gs_butterfly;
    localparam logic [63:0] P    = 64'hFFFF_FFFF_0000_0001;
    localparam int          MAXC = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_a, in_b, in_w;
    logic        in_wsel;
    logic [7:0]  in_tag;

    logic        ov0, ov1, ov2;
    logic [63:0] ox0, ox1, ox2, oy0, oy1, oy2;
    logic [7:0]  ot0, ot1, ot2;

    always #5 clk = ~clk;

    ntt_gs_butterfly #(.MODE(0), .TAG_W(8)) u_gen (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_w(in_w), .in_wsel(in_wsel), .in_tag(in_tag),
        .out_valid(ov0), .out_x(ox0), .out_y(oy0), .out_tag(ot0));

    ntt_gs_butterfly #(.MODE(1), .TAG_W(8)) u_w0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_w(in_w), .in_wsel(in_wsel), .in_tag(in_tag),
        .out_valid(ov1), .out_x(ox1), .out_y(oy1), .out_tag(ot1));

    ntt_gs_butterfly #(.MODE(2), .TAG_W(8)) u_w02 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_w(in_w), .in_wsel(in_wsel), .in_tag(in_tag),
        .out_valid(ov2), .out_x(ox2), .out_y(oy2), .out_tag(ot2));

    typedef struct {
        bit          v;
        logic [63:0] a, b, w;
        bit          ws;
        logic [7:0]  tag;
    } beat_t;

    typedef struct {
        int          m;
        logic [63:0] a, b, w;
        bit          ws;
        logic [7:0]  tag;
        logic [63:0] ex, ey;
    } vec_t;

    beat_t hist [MAXC];
    vec_t  vec  [10];
    int    cyc     = 0;
    int    n_pass  = 0;
    int    n_total = 0;

    function automatic int lat(int m);
        case (m)
            0:       return 28;
            1:       return 6;
            default: return 14;
        endcase
    endfunction

    function automatic logic [63:0] ref_x(logic [63:0] a, logic [63:0] b);
        return 64'(({64'h0, a} + {64'h0, b}) % {64'h0, P});
    endfunction

    function automatic logic [63:0] ref_y(int m, logic [63:0] a, logic [63:0] b,
                                          logic [63:0] w, bit ws);
        logic [127:0] d, wf;
        d = ({64'h0, a} + {64'h0, P} - {64'h0, b}) % {64'h0, P};
        case (m)
            0:       wf = {64'h0, w};
            1:       wf = 128'd1;
            default: wf = ws ? (128'd1 << 48) : 128'd1;
        endcase
        return 64'((d * wf) % {64'h0, P});
    endfunction

    function automatic logic [63:0] rnd_fe();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = P - 64'd1;
            2:       v = 64'd1;
            default: begin
                v = {$urandom, $urandom};
                if (v >= P) v = v - P;
            end
        endcase
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic get_out(int m, output logic v, output logic [63:0] x,
                           output logic [63:0] y, output logic [7:0] t);
        case (m)
            0:       begin v = ov0; x = ox0; y = oy0; t = ot0; end
            1:       begin v = ov1; x = ox1; y = oy1; t = ot1; end
            default: begin v = ov2; x = ox2; y = oy2; t = ot2; end
        endcase
    endtask

    // Every cycle: out_valid must equal in_valid from exactly L cycles ago,
    // and a valid beat must carry the model's result and its own tag.
    task automatic check_all();
        for (int m = 0; m < 3; m++) begin
            logic        v;
            logic [63:0] x, y;
            logic [7:0]  t;
            int          idx;
            bit          ev;
            get_out(m, v, x, y, t);
            idx = cyc - lat(m);
            ev  = (idx >= 0) && (idx < MAXC) && hist[idx].v;
            chk($sformatf("m%0d_valid", m), {63'h0, v}, {63'h0, ev});
            if (ev) begin
                chk($sformatf("m%0d_x", m), x, ref_x(hist[idx].a, hist[idx].b));
                chk($sformatf("m%0d_y", m), y,
                    ref_y(m, hist[idx].a, hist[idx].b, hist[idx].w, hist[idx].ws));
                chk($sformatf("m%0d_tag", m), {56'h0, t}, {56'h0, hist[idx].tag});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic drive(bit v, logic [63:0] a, logic [63:0] b, logic [63:0] w,
                         bit ws, logic [7:0] t);
        in_valid = v; in_a = a; in_b = b; in_w = w; in_wsel = ws; in_tag = t;
        if (cyc < MAXC) begin
            hist[cyc].v   = v;
            hist[cyc].a   = a;
            hist[cyc].b   = b;
            hist[cyc].w   = w;
            hist[cyc].ws  = ws;
            hist[cyc].tag = t;
        end
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 8'h0);
    endtask

    task automatic check_zero_outputs(string tagname);
        for (int m = 0; m < 3; m++) begin
            logic        v;
            logic [63:0] x, y;
            logic [7:0]  t;
            get_out(m, v, x, y, t);
            chk($sformatf("%s_m%0d_valid", tagname, m), {63'h0, v}, 64'h0);
            chk($sformatf("%s_m%0d_x", tagname, m), x, 64'h0);
            chk($sformatf("%s_m%0d_y", tagname, m), y, 64'h0);
            chk($sformatf("%s_m%0d_tag", tagname, m), {56'h0, t}, 64'h0);
        end
    endtask

    task automatic random_beats(int n, int idle_pct, inout logic [7:0] tag);
        int sent;
        sent = 0;
        while (sent < n) begin
            if ($urandom_range(0, 99) < idle_pct) begin
                idle();
            end else begin
                drive(1'b1, rnd_fe(), rnd_fe(), rnd_fe(), 1'($urandom_range(0, 1)), tag);
                tag = tag + 8'd1;
                sent++;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        logic        v;
        logic [63:0] x, y;
        logic [7:0]  t;
        logic [7:0]  tag;

        // mode, a, b, w, wsel, tag, expected x, expected y
        vec[0] = '{m:0, a:64'd5, b:64'd3, w:64'd7, ws:1'b0, tag:8'hA5,
                   ex:64'd8, ey:64'd14};
        vec[1] = '{m:0, a:64'hFFFF_FFFF_0000_0000, b:64'd2, w:64'd1, ws:1'b0, tag:8'h11,
                   ex:64'd1, ey:64'hFFFF_FFFE_FFFF_FFFE};
        vec[2] = '{m:0, a:64'd0, b:64'd1, w:64'd1, ws:1'b0, tag:8'h12,
                   ex:64'd1, ey:64'hFFFF_FFFF_0000_0000};
        vec[3] = '{m:0, a:64'h8000_0000_0000_0000, b:64'h7FFF_FFFF_0000_0001,
                   w:64'hFFFF_FFFF_0000_0000, ws:1'b0, tag:8'h13,
                   ex:64'd0, ey:64'hFFFF_FFFE_0000_0002};
        vec[4] = '{m:0, a:64'h1_2345_6789, b:64'h1_2345_6789, w:64'h1234_5678_9ABC_DEF0,
                   ws:1'b0, tag:8'h14, ex:64'h2_468A_CF12, ey:64'd0};
        vec[5] = '{m:2, a:64'd1, b:64'd0, w:64'd0, ws:1'b1, tag:8'h21,
                   ex:64'd1, ey:64'h0001_0000_0000_0000};
        vec[6] = '{m:2, a:64'd0, b:64'd1, w:64'd0, ws:1'b1, tag:8'h22,
                   ex:64'd1, ey:64'hFFFE_FFFF_0000_0001};
        vec[7] = '{m:2, a:64'd9, b:64'd4, w:64'd0, ws:1'b0, tag:8'h23,
                   ex:64'd13, ey:64'd5};
        vec[8] = '{m:1, a:64'd7, b:64'd9, w:64'd3, ws:1'b1, tag:8'h31,
                   ex:64'd16, ey:64'hFFFF_FFFE_FFFF_FFFF};
        vec[9] = '{m:1, a:64'h8000_0000_0000_0000, b:64'h7FFF_FFFF_0000_0001, w:64'd0,
                   ws:1'b0, tag:8'h32, ex:64'd0, ey:64'h0000_0000_FFFF_FFFF};

        rst = 1'b1;
        idle();
        repeat (3) tick();
        check_zero_outputs("reset");
        #3 rst = 1'b0;
        idle();
        repeat (2) tick();

        // directed vectors: single beat, result exactly L cycles later
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vec[i].a, vec[i].b, vec[i].w, vec[i].ws, vec[i].tag);
            tick();
            idle();
            for (int k = 1; k < lat(vec[i].m); k++) tick();
            get_out(vec[i].m, v, x, y, t);
            chk($sformatf("vec%0d_valid", i), {63'h0, v}, 64'h1);
            chk($sformatf("vec%0d_x", i), x, vec[i].ex);
            chk($sformatf("vec%0d_y", i), y, vec[i].ey);
            chk($sformatf("vec%0d_tag", i), {56'h0, t}, {56'h0, vec[i].tag});
            repeat (3) tick();
        end

        // random traffic, ~30% gaps, incrementing tags
        tag = 8'h00;
        random_beats(1000, 30, tag);
        repeat (30) tick();

        // fill every pipeline, then reset asynchronously mid-cycle
        random_beats(40, 0, tag);
        #3 rst = 1'b1;
        #1 check_zero_outputs("async_rst");
        for (int i = 0; i < MAXC; i++) hist[i].v = 1'b0;
        repeat (2) tick();
        #4 rst = 1'b0;
        idle();
        repeat (32) tick();

        // fresh beats after release
        random_beats(60, 20, tag);
        repeat (32) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
